telemetry_tx_arbiter: RTL and testbench
=======================================

Name: telemetry_tx_arbiter

Overview:
Shares the single 8-bit uart_tx transmitter between two telemetry record FIFOs: the tachometer PID record and the IR wall-distance PID record. It arbitrates round-robin between non-empty FIFOs and pops one DATA_WIDTH-bit record. It then serialises that record as a framed byte stream (sync, channel ID, data bytes MSB-first, optional checksum) through the uart_tx start/done handshake. It replaces the single-FIFO uart data FSM at the top level.

Parameters:
DATA_WIDTH, 128, record width in bits; must be a multiple of 8.
SYNC_BYTE, 8'hA5, first byte of every frame.
CH0_ID, 8'h00, ID byte sent for records from FIFO 0 (tachometer).
CH1_ID, 8'h01, ID byte sent for records from FIFO 1 (IR distance).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  arbitration enable (uart_en_sw); gates only the start of new frames
fifo0_empty  input  1  FIFO 0 empty flag
fifo0_dout  input  DATA_WIDTH  FIFO 0 read data, valid the cycle after rd_en
fifo0_rd_en  output  1  FIFO 0 pop strobe
fifo1_empty  input  1  FIFO 1 empty flag
fifo1_dout  input  DATA_WIDTH  FIFO 1 read data, valid the cycle after rd_en
fifo1_rd_en  output  1  FIFO 1 pop strobe
uart_start_tx  output  1  one-cycle pulse; transmits uart_tx_din
uart_tx_din  output  8  byte to transmit, held stable until uart_tx_done
uart_tx_done  input  1  one-cycle pulse when the byte is fully shifted out
busy  output  1  high whenever the FSM is not in IDLE
frame_done  output  1  one-cycle pulse after the last byte's done

Behaviour:
- All outputs are registered. Reset values: rd_en 0/0, uart_start_tx 0, uart_tx_din 8'h00, busy 0, frame_done 0.
- Reset internal state: state IDLE, byte index 0, last_grant 1 (so channel 0 wins the first tie).
- States: IDLE, POP, LATCH, SEND, WAIT, DONE.
- IDLE, with en=1 and at least one FIFO non-empty:
  - grant the only non-empty channel; if both are non-empty, grant !last_grant.
  - assert that channel's rd_en for exactly 1 cycle (POP); update last_grant.
  - en=0 or both FIFOs empty: stay in IDLE.
- LATCH: capture the granted dout into a shift register, one cycle after rd_en.
- SEND: drive uart_tx_din with the current frame byte and pulse uart_start_tx for 1 cycle, then go to WAIT.
- WAIT: hold uart_tx_din. On uart_tx_done, go to SEND with the next byte if one remains, otherwise go to DONE.
- DONE: pulse frame_done for 1 cycle, then return to IDLE. The next arbitration is evaluated the cycle after.
- Frame byte order: SYNC_BYTE, channel ID, then DATA_WIDTH/8 data bytes, MSB byte first.
  - Frame length is 2+DATA_WIDTH/8 bytes (18 at default).
- Latency: empty falls in IDLE, rd_en rises at the next edge. First uart_start_tx is 3 cycles after empty falls. Each following start pulse is 1 cycle after uart_tx_done.
- uart_tx_done is ignored outside WAIT. uart_start_tx is never reasserted before done.
- en deasserted mid-frame: the current frame completes; no new frame starts.
- A FIFO's empty flag changing mid-frame has no effect. rd_en is never asserted while the FIFO is empty, and at most once per frame.
- Reset mid-frame: immediate return to the reset state. The partial frame is abandoned; the popped record is lost.

Optional Feature:
Macro TELEM_CHECKSUM_EN.
- Defined: a checksum byte is appended after the last data byte, making the frame 3+DATA_WIDTH/8 bytes.
  - Checksum = XOR of the ID byte and all data bytes; SYNC is excluded.
  - It is sent with the same start/done handshake before DONE.
- Undefined: no checksum byte, no checksum logic.

Test Plan:
- FIFO0 holds record 128'h0011..FF, FIFO1 empty, en=1, done returned 10 cycles after each start:
  - fifo0_rd_en pulses once.
  - Bytes A5,00,00,11,…,FF are sent (18 bytes).
  - frame_done pulses once; busy then falls.
- Both FIFOs non-empty with 2 records each:
  - channel order is 0,1,0,1 and ID bytes are 00,01,00,01.
  - each rd_en pulses exactly twice.
- en dropped after the 5th byte's done:
  - the frame finishes all 18 bytes.
  - no further rd_en while en=0; the next frame starts 3 cycles after en returns to 1.
- Spurious uart_tx_done pulses in IDLE and in SEND: no byte skipped, no extra start pulses, byte count unchanged.
- Reset asserted during WAIT of byte 7:
  - all outputs are 0 on the same cycle.
  - after release with both FIFOs non-empty, channel 0 is granted first.
- TELEM_CHECKSUM_EN defined, record of all 8'h01 bytes with ID 00: the 19th byte is 8'h00 (16 XORed 01s). With record byte0=8'h5A and the rest 00, the checksum is 8'h5A.

Source files
------------

// File: rtl/telemetry_tx_arbiter.sv
// rtl/telemetry_tx_arbiter.sv - round-robin arbiter framing two telemetry FIFOs onto one uart_tx.
// Optional checksum byte enabled by TELEM_CHECKSUM_EN.
module telemetry_tx_arbiter #(
  parameter int         DATA_WIDTH = 128,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter logic [7:0] CH0_ID     = 8'h00,
  parameter logic [7:0] CH1_ID     = 8'h01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  fifo0_empty,
  input  logic [DATA_WIDTH-1:0] fifo0_dout,
  output logic                  fifo0_rd_en,
  input  logic                  fifo1_empty,
  input  logic [DATA_WIDTH-1:0] fifo1_dout,
  output logic                  fifo1_rd_en,
  output logic                  uart_start_tx,
  output logic [7:0]            uart_tx_din,
  input  logic                  uart_tx_done,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int N_DATA = DATA_WIDTH / 8;
`ifdef TELEM_CHECKSUM_EN
  localparam int FRAME_LEN = N_DATA + 3;
`else
  localparam int FRAME_LEN = N_DATA + 2;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);

  localparam logic [IDX_W-1:0] IDX_ID    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_DATA0 = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_DEND  = IDX_W'(N_DATA + 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_chan;
  logic                  r_last_grant;
  logic                  r_fifo0_rd_en;
  logic                  r_fifo1_rd_en;
  logic                  r_start;
  logic [7:0]            r_din;
  logic                  r_busy;
  logic                  r_frame_done;
`ifdef TELEM_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic       w_req0;
  logic       w_req1;
  logic       w_grant1;
  logic       w_is_data;
  logic [7:0] w_byte;

  assign w_req0    = !fifo0_empty;
  assign w_req1    = !fifo1_empty;
  // Channel 1 wins when it is the only requester, or on a tie when channel 0 went last.
  assign w_grant1  = w_req1 && (!w_req0 || !r_last_grant);
  assign w_is_data = (r_idx >= IDX_DATA0) && (r_idx < IDX_DEND);

  // r_idx holds the count of bytes already launched, i.e. the index of the next byte.
  always_comb begin
    w_byte = r_shreg[DATA_WIDTH-1 -: 8];
    if (r_idx == IDX_ID) begin
      w_byte = r_chan ? CH1_ID : CH0_ID;
    end
`ifdef TELEM_CHECKSUM_EN
    else if (r_idx == IDX_DEND) begin
      w_byte = r_csum;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_shreg       <= '0;
      r_chan        <= 1'b0;
      r_last_grant  <= 1'b1;
      r_fifo0_rd_en <= 1'b0;
      r_fifo1_rd_en <= 1'b0;
      r_start       <= 1'b0;
      r_din         <= 8'h00;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
`ifdef TELEM_CHECKSUM_EN
      r_csum        <= 8'h00;
`endif
    end else begin
      r_fifo0_rd_en <= 1'b0;
      r_fifo1_rd_en <= 1'b0;
      r_start       <= 1'b0;
      r_frame_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && (w_req0 || w_req1)) begin
            r_chan        <= w_grant1;
            r_last_grant  <= w_grant1;
            r_fifo0_rd_en <= !w_grant1;
            r_fifo1_rd_en <= w_grant1;
            r_busy        <= 1'b1;
            r_state       <= S_POP;
          end
        end
        S_POP: begin
          r_state <= S_LATCH;
        end
        // FIFO data is valid now; SYNC needs no record data so it launches on the same edge.
        S_LATCH: begin
          r_shreg <= r_chan ? fifo1_dout : fifo0_dout;
          r_din   <= SYNC_BYTE;
          r_start <= 1'b1;
          r_idx   <= IDX_ID;
`ifdef TELEM_CHECKSUM_EN
          r_csum  <= 8'h00;
`endif
          r_state <= S_SEND;
        end
        S_SEND: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (uart_tx_done) begin
            if (r_idx == IDX_LAST) begin
              r_frame_done <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_din   <= w_byte;
              r_start <= 1'b1;
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SEND;
              if (w_is_data) begin
                r_shreg <= r_shreg << 8;
              end
`ifdef TELEM_CHECKSUM_EN
              if (r_idx != IDX_DEND) begin
                r_csum <= r_csum ^ w_byte;
              end
`endif
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fifo0_rd_en   = r_fifo0_rd_en;
  assign fifo1_rd_en   = r_fifo1_rd_en;
  assign uart_start_tx = r_start;
  assign uart_tx_din   = r_din;
  assign busy          = r_busy;
  assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_telemetry_tx_arbiter.sv
// tb/tb_telemetry_tx_arbiter.sv - self-checking bench for telemetry_tx_arbiter.
module tb_telemetry_tx_arbiter;

  localparam int DW = 128;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          fifo0_empty;
  logic [DW-1:0] fifo0_dout;
  logic          fifo0_rd_en;
  logic          fifo1_empty;
  logic [DW-1:0] fifo1_dout;
  logic          fifo1_rd_en;
  logic          uart_start_tx;
  logic [7:0]    uart_tx_din;
  logic          uart_tx_done;
  logic          busy;
  logic          frame_done;

  telemetry_tx_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .en            (en),
    .fifo0_empty   (fifo0_empty),
    .fifo0_dout    (fifo0_dout),
    .fifo0_rd_en   (fifo0_rd_en),
    .fifo1_empty   (fifo1_empty),
    .fifo1_dout    (fifo1_dout),
    .fifo1_rd_en   (fifo1_rd_en),
    .uart_start_tx (uart_start_tx),
    .uart_tx_din   (uart_tx_din),
    .uart_tx_done  (uart_tx_done),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic [DW-1:0] mq0[$];
  logic [DW-1:0] mq1[$];
  logic [7:0]    rx[$];
  logic [7:0]    exp_q[$];
  bit            m_last = 1'b1;

  int rd0_cnt, rd1_cnt, fd_cnt, start_cnt, done_cnt;
  int cyc = 0;
  int t_fall0 = -1;
  int t_rd0 = -1;
  int t_start = -1;
  int dly = 10;
  int ucnt = 0;
  bit pending = 1'b0;
  bit spur_send = 1'b0;
  bit spur_now = 1'b0;

  typedef struct {
    int         n0;
    int         n1;
    int         dly;
    int         frames;
    int         rd0;
    int         rd1;
    logic [7:0] first_id;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: a frame is SYNC, ID, data MSB-first, then optionally XOR of ID and data.
  task automatic model_frame(input bit ch, input logic [DW-1:0] rec);
    logic [7:0] id;
    logic [7:0] cs;
    logic [7:0] b;
    id = ch ? 8'h01 : 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(id);
    cs = id;
    for (int i = NB - 1; i >= 0; i--) begin
      b = rec[i*8 +: 8];
      exp_q.push_back(b);
      cs = cs ^ b;
    end
`ifdef TELEM_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic model_step();
    bit g;
    logic [DW-1:0] rec;
    if (mq0.size() == 0 && mq1.size() == 0) return;
    if (mq0.size() != 0 && mq1.size() != 0) g = !m_last;
    else g = (mq1.size() != 0);
    m_last = g;
    rec = g ? mq1.pop_front() : mq0.pop_front();
    model_frame(g, rec);
  endtask

  task automatic model_drain();
    while (mq0.size() != 0 || mq1.size() != 0) model_step();
  endtask

  task automatic push(input bit ch, input logic [DW-1:0] rec);
    if (ch) begin q1.push_back(rec); mq1.push_back(rec); end
    else begin q0.push_back(rec); mq0.push_back(rec); end
  endtask

  function automatic logic [DW-1:0] rnd_rec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_log();
    rx.delete();
    exp_q.delete();
    rd0_cnt = 0; rd1_cnt = 0; fd_cnt = 0; start_cnt = 0; done_cnt = 0;
    t_fall0 = -1; t_rd0 = -1; t_start = -1;
  endtask

  task automatic wait_frames(input int n, input string name);
    int k;
    k = 0;
    while (fd_cnt < n && k < 8000) begin
      @(negedge clk);
      k++;
    end
    repeat (30) @(negedge clk);
    chk({name, "_frames"}, fd_cnt, n);
  endtask

  task automatic cmp_stream(input string name);
    int nmis;
    int first;
    nmis = 0;
    first = -1;
    chk({name, "_len"}, rx.size(), exp_q.size());
    for (int i = 0; i < rx.size() && i < exp_q.size(); i++) begin
      if (rx[i] !== exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    if (first >= 0) $display("  %s first diff at byte %0d: %0h vs %0h", name, first, rx[first], exp_q[first]);
    chk({name, "_bytes_wrong"}, nmis, 0);
  endtask

  // FIFO and uart_tx behavioural models, updated just after each rising edge.
  initial begin
    fifo0_empty = 1'b1;
    fifo1_empty = 1'b1;
    fifo0_dout = '0;
    fifo1_dout = '0;
    uart_tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      uart_tx_done = 1'b0;
      if (reset) begin
        ucnt = 0;
        pending = 1'b0;
      end else begin
        if (fifo0_rd_en) begin
          chk("rd0_while_empty", fifo0_empty, 0);
          chk("rd0_with_rd1", fifo1_rd_en, 0);
          if (q0.size() > 0) fifo0_dout = q0.pop_front();
          rd0_cnt++;
          if (t_rd0 < 0) t_rd0 = cyc;
        end
        if (fifo1_rd_en) begin
          chk("rd1_while_empty", fifo1_empty, 0);
          if (q1.size() > 0) fifo1_dout = q1.pop_front();
          rd1_cnt++;
        end
        if (ucnt > 0) begin
          ucnt--;
          if (ucnt == 0) begin
            uart_tx_done = 1'b1;
            pending = 1'b0;
            done_cnt++;
          end
        end
        if (uart_start_tx) begin
          chk("start_before_done", pending, 0);
          pending = 1'b1;
          ucnt = dly;
          rx.push_back(uart_tx_din);
          start_cnt++;
          if (t_start < 0) t_start = cyc;
          if (spur_send) uart_tx_done = 1'b1;
        end
        if (spur_now) begin
          uart_tx_done = 1'b1;
          spur_now = 1'b0;
        end
        if (frame_done) fd_cnt++;
      end
      if (fifo0_empty && q0.size() > 0 && t_fall0 < 0) t_fall0 = cyc;
      fifo0_empty = (q0.size() == 0);
      fifo1_empty = (q1.size() == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int k;
    int n0;
    int n1;
    logic [7:0] b;

    tbl[0] = '{2, 2, 3, 4, 2, 2, 8'h00};
    tbl[1] = '{1, 0, 10, 1, 1, 0, 8'h00};
    tbl[2] = '{0, 3, 1, 3, 0, 3, 8'h01};
    tbl[3] = '{3, 1, 5, 4, 3, 1, 8'h00};
    tbl[4] = '{1, 2, 2, 3, 1, 2, 8'h01};

    reset = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {fifo0_rd_en, fifo1_rd_en, uart_start_tx, frame_done, uart_tx_din}, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      clear_log();
      dly = tbl[v].dly;
      for (int i = 0; i < tbl[v].n0; i++) push(1'b0, rnd_rec());
      for (int i = 0; i < tbl[v].n1; i++) push(1'b1, rnd_rec());
      model_drain();
      wait_frames(tbl[v].frames, $sformatf("vec%0d", v));
      cmp_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_rd0", v), rd0_cnt, tbl[v].rd0);
      chk($sformatf("vec%0d_rd1", v), rd1_cnt, tbl[v].rd1);
      b = (rx.size() > 1) ? rx[1] : 8'hEE;
      chk($sformatf("vec%0d_first_id", v), b, tbl[v].first_id);
    end

    // Single record, latency from empty falling and busy after frame.
    @(negedge clk);
    clear_log();
    dly = 10;
    push(1'b0, 128'h00112233445566778899AABBCCDDEEFF);
    model_drain();
    wait_frames(1, "single");
    cmp_stream("single");
    chk("single_rd0", rd0_cnt, 1);
    chk("lat_rd_en", t_rd0 - t_fall0, 1);
    chk("lat_first_start", t_start - t_fall0, 3);
    chk("single_busy_after", busy, 0);

    // en dropped mid-frame.
    @(negedge clk);
    clear_log();
    dly = 4;
    push(1'b0, rnd_rec());
    push(1'b0, rnd_rec());
    k = 0;
    while (done_cnt < 5 && k < 2000) begin @(negedge clk); k++; end
    en = 1'b0;
    chk("endrop_busy_mid", busy, 1);
    model_step();
    wait_frames(1, "endrop");
    repeat (20) @(negedge clk);
    cmp_stream("endrop");
    chk("endrop_rd0", rd0_cnt, 1);
    en = 1'b1;
    k = 0;
    while (k < 10) begin
      @(posedge clk);
      #1;
      k++;
      if (uart_start_tx) break;
    end
    chk("en_restart_lat", k, 3);
    model_step();
    wait_frames(2, "enback");
    cmp_stream("enback");
    chk("enback_rd0", rd0_cnt, 2);

    // Spurious done pulses in IDLE and during start pulses.
    @(negedge clk);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      spur_now = 1'b1;
      repeat (4) @(negedge clk);
    end
    chk("spur_idle_starts", start_cnt, 0);
    chk("spur_idle_busy", busy, 0);
    dly = 3;
    spur_send = 1'b1;
    push(1'b1, rnd_rec());
    model_drain();
    wait_frames(1, "spur_send");
    spur_send = 1'b0;
    cmp_stream("spur_send");
    chk("spur_send_starts", start_cnt, exp_q.size());

    // Reset during WAIT of byte 7.
    @(negedge clk);
    clear_log();
    dly = 6;
    q0.push_back(rnd_rec());
    k = 0;
    while (start_cnt < 7 && k < 2000) begin @(negedge clk); k++; end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midreset_outputs", {fifo0_rd_en, fifo1_rd_en, uart_start_tx, frame_done, uart_tx_din}, 0);
    chk("midreset_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    clear_log();
    push(1'b0, rnd_rec());
    push(1'b1, rnd_rec());
    model_drain();
    wait_frames(2, "postreset");
    cmp_stream("postreset");
    b = (rx.size() > 1) ? rx[1] : 8'hEE;
    chk("postreset_first_id", b, 8'h00);

`ifdef TELEM_CHECKSUM_EN
    @(negedge clk);
    clear_log();
    dly = 2;
    push(1'b0, {16{8'h01}});
    model_drain();
    wait_frames(1, "csum_ones");
    b = (rx.size() > 18) ? rx[18] : 8'hEE;
    chk("csum_ones", b, 8'h00);
    @(negedge clk);
    clear_log();
    push(1'b0, {8'h5A, 120'h0});
    model_drain();
    wait_frames(1, "csum_5a");
    b = (rx.size() > 18) ? rx[18] : 8'hEE;
    chk("csum_5a", b, 8'h5A);
`endif

    // Randomised record counts and uart latency.
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      clear_log();
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      dly = $urandom_range(1, 6);
      for (int i = 0; i < n0; i++) push(1'b0, rnd_rec());
      for (int i = 0; i < n1; i++) push(1'b1, rnd_rec());
      model_drain();
      wait_frames(n0 + n1, $sformatf("rnd%0d", r));
      cmp_stream($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_rd0", r), rd0_cnt, n0);
      chk($sformatf("rnd%0d_rd1", r), rd1_cnt, n1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
